// File: rtl/test_harness_sequencer.sv
// -----------------------------------------------------------------------------
// test_harness_sequencer
//
// Launches NUM_CH sub-harness channels, either all at once (concurrent) or one
// after another (sequential), latches each channel's pass bit on its done edge,
// enforces a per-channel cycle timeout and reports aggregate completion/pass.
//
// Optional feature: define HARNESS_FAIL_INDEX_EN to add first_fail_valid /
// first_fail_idx, which record the first channel that resolved as failed or
// timed out (lowest index wins on a tie).
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   start_tests  run request, rising edge starts a run
//   seq_mode     0 = concurrent, 1 = sequential (sampled on the start edge)
//   ch_start     per-channel start level, high while the channel runs
//   ch_done      per-channel done, rising edge = done
//   ch_pass      per-channel pass bit, sampled with the done edge
//   ch_result    latched pass bit per channel
//   ch_timeout   latched timeout flag per channel
//   busy         high from start until the run completes
//   all_done     high once the run completes, held until the next start
//   all_pass     valid with all_done: every channel passed, none timed out
// -----------------------------------------------------------------------------
module test_harness_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 1000,
    localparam int IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_tests,
    input  logic              seq_mode,
    output logic [NUM_CH-1:0] ch_start,
    input  logic [NUM_CH-1:0] ch_done,
    input  logic [NUM_CH-1:0] ch_pass,
    output logic [NUM_CH-1:0] ch_result,
    output logic [NUM_CH-1:0] ch_timeout,
    output logic              busy,
    output logic              all_done,
    output logic              all_pass
`ifdef HARNESS_FAIL_INDEX_EN
    ,
    output logic              first_fail_valid,
    output logic [IDX_W-1:0]  first_fail_idx
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_ALL = 2'd1,
        RUN_ONE = 2'd2,
        FINISH  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [TIMEOUT_W-1:0] LAST_CNT = TIMEOUT_W'(TIMEOUT_CYC - 1);
    localparam logic [NUM_CH-1:0]    CH_ONE   = NUM_CH'(1'b1);

    state_t                 state_r, stateNext_s;
    logic                   startQ_r;
    logic [NUM_CH-1:0]      doneQ_r;
    logic [TIMEOUT_W-1:0]   counter_r, counterNext_s;
    logic [IDX_W-1:0]       index_r, indexNext_s;

    logic [NUM_CH-1:0]      chStartNext_s, resultNext_s, timeoutNext_s;
    logic                   busyNext_s, allDoneNext_s, allPassNext_s;

    logic                   startEdge_s, launch_s, timeoutHit_s;
    logic [NUM_CH-1:0]      doneEdge_s, resolvedDone_s, timedOut_s, remaining_s;

`ifdef HARNESS_FAIL_INDEX_EN
    logic                   ffValidNext_s;
    logic [IDX_W-1:0]       ffIdxNext_s;
    logic [NUM_CH-1:0]      failNow_s;

    // Lowest set bit of a channel vector, used to pick the first failure.
    function automatic logic [IDX_W-1:0] lowestSet(input logic [NUM_CH-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction
`endif

    // Edge detection and per-channel resolution for the current cycle.
    always_comb begin
        startEdge_s    = start_tests & ~startQ_r;
        doneEdge_s     = ch_done & ~doneQ_r;
        // A launch is only accepted once the previous run has fully reported.
        launch_s       = startEdge_s & ~busy & ((state_r == IDLE) | (state_r == FINISH));
        timeoutHit_s   = (counter_r == LAST_CNT);
        // Only started channels may resolve; a done edge beats a timeout.
        resolvedDone_s = doneEdge_s & ch_start;
        if (timeoutHit_s) begin
            timedOut_s = ch_start & ~resolvedDone_s;
        end else begin
            timedOut_s = '0;
        end
        remaining_s    = ch_start & ~resolvedDone_s & ~timedOut_s;
`ifdef HARNESS_FAIL_INDEX_EN
        failNow_s      = (resolvedDone_s & ~ch_pass) | timedOut_s;
`endif
    end

    // Next-state logic.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE, FINISH: begin
                if (launch_s) begin
                    stateNext_s = seq_mode ? RUN_ONE : RUN_ALL;
                end else begin
                    stateNext_s = state_r;
                end
            end
            RUN_ALL: begin
                if (remaining_s == '0) begin
                    stateNext_s = FINISH;
                end else begin
                    stateNext_s = RUN_ALL;
                end
            end
            RUN_ONE: begin
                if ((remaining_s == '0) && (index_r == LAST_IDX)) begin
                    stateNext_s = FINISH;
                end else begin
                    stateNext_s = RUN_ONE;
                end
            end
            default: stateNext_s = IDLE;
        endcase
    end

    // Next values of the registered outputs, counter and channel index.
    always_comb begin
        chStartNext_s = ch_start;
        resultNext_s  = ch_result;
        timeoutNext_s = ch_timeout;
        busyNext_s    = busy;
        allDoneNext_s = all_done;
        allPassNext_s = all_pass;
        counterNext_s = counter_r;
        indexNext_s   = index_r;
`ifdef HARNESS_FAIL_INDEX_EN
        ffValidNext_s = first_fail_valid;
        ffIdxNext_s   = first_fail_idx;
`endif
        case (state_r)
            IDLE, FINISH: begin
                if (launch_s) begin
                    resultNext_s  = '0;
                    timeoutNext_s = '0;
                    allDoneNext_s = 1'b0;
                    allPassNext_s = 1'b0;
                    counterNext_s = '0;
                    busyNext_s    = 1'b1;
                    indexNext_s   = '0;
`ifdef HARNESS_FAIL_INDEX_EN
                    ffValidNext_s = 1'b0;
                    ffIdxNext_s   = '0;
`endif
                    if (seq_mode) begin
                        chStartNext_s = CH_ONE;
                    end else begin
                        chStartNext_s = {NUM_CH{1'b1}};
                    end
                end else if (state_r == FINISH) begin
                    busyNext_s    = 1'b0;
                    allDoneNext_s = 1'b1;
                    allPassNext_s = (&ch_result) & ~(|ch_timeout);
                end else begin
                    busyNext_s    = busy;
                end
            end
            RUN_ALL, RUN_ONE: begin
                resultNext_s  = (ch_result & ~(resolvedDone_s | timedOut_s))
                              | (ch_pass & resolvedDone_s);
                timeoutNext_s = ch_timeout | timedOut_s;
                chStartNext_s = remaining_s;
                counterNext_s = counter_r + TIMEOUT_W'(1);
`ifdef HARNESS_FAIL_INDEX_EN
                if (!first_fail_valid && (failNow_s != '0)) begin
                    ffValidNext_s = 1'b1;
                    ffIdxNext_s   = lowestSet(failNow_s);
                end else begin
                    ffValidNext_s = first_fail_valid;
                end
`endif
                // Sequential hand-off: next channel starts on the resolving edge.
                if ((state_r == RUN_ONE) && (remaining_s == '0)) begin
                    counterNext_s = '0;
                    if (index_r != LAST_IDX) begin
                        indexNext_s   = index_r + IDX_W'(1);
                        chStartNext_s = CH_ONE << (index_r + IDX_W'(1));
                    end else begin
                        indexNext_s   = index_r;
                    end
                end else begin
                    indexNext_s = index_r;
                end
            end
            default: begin
                chStartNext_s = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            startQ_r   <= 1'b0;
            doneQ_r    <= '0;
            counter_r  <= '0;
            index_r    <= '0;
            ch_start   <= '0;
            ch_result  <= '0;
            ch_timeout <= '0;
            busy       <= 1'b0;
            all_done   <= 1'b0;
            all_pass   <= 1'b0;
`ifdef HARNESS_FAIL_INDEX_EN
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
`endif
        end else begin
            state_r    <= stateNext_s;
            startQ_r   <= start_tests;
            doneQ_r    <= ch_done;
            counter_r  <= counterNext_s;
            index_r    <= indexNext_s;
            ch_start   <= chStartNext_s;
            ch_result  <= resultNext_s;
            ch_timeout <= timeoutNext_s;
            busy       <= busyNext_s;
            all_done   <= allDoneNext_s;
            all_pass   <= allPassNext_s;
`ifdef HARNESS_FAIL_INDEX_EN
            first_fail_valid <= ffValidNext_s;
            first_fail_idx   <= ffIdxNext_s;
`endif
        end
    end

endmodule

// File: tb/tb_test_harness_sequencer.sv
// Self-checking bench for test_harness_sequencer (NUM_CH=4, TIMEOUT_CYC=50).
// Each run is described by per-channel done delays (counted from that
// channel's own launch) and pass bits; a timeline model derives when every
// channel starts and resolves and what the run must report.
module tb_test_harness_sequencer;

    localparam int NCH   = 4;
    localparam int TO    = 50;
    localparam int MAXC  = 300;
    localparam int NRAND = 12;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_tests = 1'b0;
    logic seq_mode = 1'b0;
    logic [NCH-1:0] ch_start, ch_done, ch_pass, ch_result, ch_timeout;
    logic busy, all_done, all_pass;
`ifdef HARNESS_FAIL_INDEX_EN
    logic ffValid;
    logic [1:0] ffIdx;
`endif

    test_harness_sequencer #(.NUM_CH(NCH), .TIMEOUT_W(16), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .start_tests(start_tests), .seq_mode(seq_mode),
        .ch_start(ch_start), .ch_done(ch_done), .ch_pass(ch_pass),
        .ch_result(ch_result), .ch_timeout(ch_timeout),
        .busy(busy), .all_done(all_done), .all_pass(all_pass)
`ifdef HARNESS_FAIL_INDEX_EN
        , .first_fail_valid(ffValid), .first_fail_idx(ffIdx)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Scenario knobs
    int dly [NCH];
    bit pas [NCH];
    int lateCh, lateAt, preHigh, midStartAt;

    // Model results
    int st [NCH];
    int rs [NCH];
    bit expTo [NCH];
    bit expRes [NCH];
    int E;
    bit expFfV;
    int expFfI;

    // Observations, index c = value after edge c of the run (edge 0 = launch)
    logic [NCH-1:0] obsStart [0:MAXC];
    logic [NCH-1:0] obsResult [0:MAXC];
    logic [NCH-1:0] obsTimeout [0:MAXC];
    logic obsBusy [0:MAXC];
    logic obsAllDone [0:MAXC];
    logic obsAllPass [0:MAXC];
    logic obsFfV [0:MAXC];
    int   obsFfI [0:MAXC];

    task automatic clear_knobs();
        lateCh = -1; lateAt = 0; preHigh = -1; midStartAt = -1;
    endtask

    // Timeline model: concurrent channels all start at edge 0; sequential
    // channels start where the previous one resolved. A channel resolves
    // after min(delay, TO) of its own edges; delay > TO means timed out.
    task automatic compute_model(input bit mode);
        int t;
        int eff;
        int best;
        t = 0; E = 0; best = -1;
        for (int i = 0; i < NCH; i++) begin
            eff = (dly[i] > TO) ? TO : dly[i];
            st[i] = mode ? t : 0;
            rs[i] = st[i] + eff;
            if (mode) t = rs[i];
            expTo[i]  = (dly[i] > TO);
            expRes[i] = !expTo[i] && pas[i];
            if (rs[i] > E) E = rs[i];
            if (!expRes[i] && (best < 0 || rs[i] < rs[best])) best = i;
        end
        expFfV = (best >= 0);
        expFfI = (best >= 0) ? best : 0;
    endtask

    // Drives one run from the launch edge to two edges past the last resolve.
    task automatic drive_run(input bit mode);
        int e;
        @(negedge clk);
        start_tests = 1'b1;
        seq_mode = mode;
        ch_done = '0;
        for (int i = 0; i < NCH; i++) ch_pass[i] = pas[i];
        if (preHigh >= 0) ch_done[preHigh] = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= E + 2; c++) begin
            @(negedge clk);
            obsStart[c] = ch_start;  obsResult[c] = ch_result; obsTimeout[c] = ch_timeout;
            obsBusy[c] = busy; obsAllDone[c] = all_done; obsAllPass[c] = all_pass;
`ifdef HARNESS_FAIL_INDEX_EN
            obsFfV[c] = ffValid; obsFfI[c] = int'(ffIdx);
`else
            obsFfV[c] = 1'b0; obsFfI[c] = 0;
`endif
            seq_mode = ~mode;
            start_tests = (midStartAt > 0) && (c >= midStartAt) && (c < midStartAt + 3);
            e = c + 1;
            for (int i = 0; i < NCH; i++) begin
                ch_done[i] = (e == st[i] + dly[i]) || (e == st[i] + dly[i] + 1)
                          || ((i == lateCh) && ((e == lateAt) || (e == lateAt + 1)))
                          || ((i == preHigh) && (e <= 1));
            end
        end
        ch_done = '0;
        start_tests = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (ch_start !== 4'b0000) begin bad++; $display("FAIL reset_ch_start got=%b exp=0000", ch_start); end
        total++; if (ch_result !== 4'b0000 || ch_timeout !== 4'b0000) begin
            bad++; $display("FAIL reset_latches got=%b/%b exp=0000/0000", ch_result, ch_timeout); end
        total++; if ({busy, all_done, all_pass} !== 3'b000) begin
            bad++; $display("FAIL reset_status got=%b exp=000", {busy, all_done, all_pass}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_runs();
        bit mode;
        logic [NCH-1:0] expS, expR, expT;
        bit expP;
        for (int r = 0; r < 8 + NRAND; r++) begin
            clear_knobs();
            pas = '{1'b1, 1'b1, 1'b1, 1'b1};
            mode = 1'b0;
            case (r)
                0: dly = '{5, 9, 12, 20};
                1: begin dly = '{4, 7, 6, 10}; pas[2] = 1'b0; end
                2: dly = '{5, 8, 11, TO + 20};
                3: begin mode = 1'b1; dly = '{3, 3, 3, 3}; lateCh = 0; lateAt = 8; end
                4: dly = '{5, TO, 7, 9};
                5: begin mode = 1'b1; dly = '{2, TO, 3, TO + 5}; pas[1] = 1'b0; end
                6: begin dly = '{10, 12, 15, 18}; midStartAt = 2; end
                7: begin mode = 1'b1; dly = '{6, 4, 5, 3}; midStartAt = 3; preHigh = 0; end
                default: begin
                    mode = 1'($urandom_range(0, 1));
                    for (int i = 0; i < NCH; i++) begin
                        dly[i] = $urandom_range(3, TO + 10);
                        pas[i] = 1'($urandom_range(0, 3) != 0);
                    end
                    preHigh = $urandom_range(0, NCH);
                    if (preHigh == NCH) preHigh = -1;
                end
            endcase
            compute_model(mode);
            drive_run(mode);
            for (int c = 0; c <= E + 1; c++) begin
                for (int i = 0; i < NCH; i++) expS[i] = (st[i] <= c) && (c < rs[i]);
                total++;
                if (obsStart[c] !== expS) begin
                    bad++; $display("FAIL run%0d ch_start edge%0d got=%b exp=%b", r, c, obsStart[c], expS);
                end
            end
            for (int i = 0; i < NCH; i++) begin expR[i] = expRes[i]; expT[i] = expTo[i]; end
            expP = (expR == 4'b1111) && (expT == 4'b0000);
            total++; if (obsBusy[E] !== 1'b1 || obsAllDone[E] !== 1'b0) begin
                bad++; $display("FAIL run%0d status_at_last_resolve got=%b%b exp=10", r, obsBusy[E], obsAllDone[E]); end
            total++; if (obsBusy[E+1] !== 1'b0 || obsAllDone[E+1] !== 1'b1 || obsAllDone[E+2] !== 1'b1) begin
                bad++; $display("FAIL run%0d status_finish got=%b%b%b exp=011", r, obsBusy[E+1], obsAllDone[E+1], obsAllDone[E+2]); end
            total++; if (obsResult[E+1] !== expR) begin
                bad++; $display("FAIL run%0d ch_result got=%b exp=%b", r, obsResult[E+1], expR); end
            total++; if (obsTimeout[E+1] !== expT) begin
                bad++; $display("FAIL run%0d ch_timeout got=%b exp=%b", r, obsTimeout[E+1], expT); end
            total++; if (obsAllPass[E+1] !== expP) begin
                bad++; $display("FAIL run%0d all_pass got=%b exp=%b", r, obsAllPass[E+1], expP); end
`ifdef HARNESS_FAIL_INDEX_EN
            total++; if (obsFfV[E+1] !== expFfV || obsFfI[E+1] != expFfI) begin
                bad++; $display("FAIL run%0d first_fail got=%b/%0d exp=%b/%0d", r, obsFfV[E+1], obsFfI[E+1], expFfV, expFfI); end
`endif
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_reset_midrun();
        logic [NCH-1:0] expR, expT;
        clear_knobs();
        @(negedge clk);
        start_tests = 1'b1; seq_mode = 1'b0; ch_done = '0; ch_pass = 4'b1111;
        @(negedge clk);
        start_tests = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b1 || ch_start !== 4'b1111) begin
            bad++; $display("FAIL midrun_running got=%b/%b exp=1/1111", busy, ch_start); end
        #2 reset = 1'b1;
        #1;
        total++; if (ch_start !== 4'b0000 || busy !== 1'b0) begin
            bad++; $display("FAIL midrun_async_reset got=%b/%b exp=0000/0", ch_start, busy); end
        @(negedge clk);
        total++; if ({ch_result, ch_timeout, all_done, all_pass} !== 10'b0) begin
            bad++; $display("FAIL midrun_reset_outputs got=%b exp=0", {ch_result, ch_timeout, all_done, all_pass}); end
        reset = 1'b0;
        @(negedge clk);
        // Clean run right after the reset
        for (int i = 0; i < NCH; i++) begin dly[i] = $urandom_range(3, 30); pas[i] = 1'($urandom_range(0, 1)); end
        compute_model(1'b1);
        drive_run(1'b1);
        for (int i = 0; i < NCH; i++) begin expR[i] = expRes[i]; expT[i] = expTo[i]; end
        total++; if (obsAllDone[E+1] !== 1'b1 || obsResult[E+1] !== expR || obsTimeout[E+1] !== expT) begin
            bad++; $display("FAIL rerun_after_reset got=%b/%b/%b exp=1/%b/%b",
                            obsAllDone[E+1], obsResult[E+1], obsTimeout[E+1], expR, expT); end
    endtask

    initial begin
        ch_done = '0;
        ch_pass = '0;
        clear_knobs();
        test_reset();
        test_runs();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/test_harness_sequencer.md
Name: test_harness_sequencer

Overview:
Parametrised, clocked successor to the single-channel test-bench harness. Launches NUM_CH sub-harness channels, either all concurrently or one at a time. Per channel it latches the pass/fail result on done and enforces a cycle timeout. It then reports aggregate completion and pass status to the top-level bench.

Parameters:
NUM_CH, 4, number of sub-harness channels (1..32)
TIMEOUT_W, 16, width of the timeout counter
TIMEOUT_CYC, 1000, cycles a channel may run before it is declared timed out (must be < 2^TIMEOUT_W, >= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start_tests  input  1  run request; a rising edge (sampled on clk) starts a run
seq_mode  input  1  0 = concurrent, 1 = sequential; sampled only on the start edge
ch_start  output  NUM_CH  per-channel start level, held high while that channel runs
ch_done  input  NUM_CH  per-channel test-done; rising edge = done
ch_pass  input  NUM_CH  per-channel dutPassed; sampled on the same cycle as the ch_done edge
ch_result  output  NUM_CH  latched pass bit per channel
ch_timeout  output  NUM_CH  latched timeout flag per channel
busy  output  1  high from start until the run completes
all_done  output  1  high when the run is complete; held until the next start
all_pass  output  1  valid when all_done=1: &ch_result and no ch_timeout

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs, edge-detect registers, counter and channel index = 0.
- Edge detect: start_q <= start_tests; start edge = start_tests & ~start_q. ch_done edges are detected the same way, per bit.
- States: IDLE, RUN_ALL, RUN_ONE, FINISH.
- IDLE/FINISH + start edge:
  - clear ch_result, ch_timeout, all_done, all_pass, counter; busy <= 1.
  - seq_mode=0: ch_start <= all ones; go to RUN_ALL.
  - seq_mode=1: index <= 0; ch_start <= 1 << 0; go to RUN_ONE.
  - ch_start is visible after the same edge that sees the start edge.
- RUN_ALL:
  - counter increments every cycle.
  - On a done edge for channel i with ch_start[i]=1: ch_result[i] <= ch_pass[i]; ch_start[i] <= 0.
  - If counter == TIMEOUT_CYC-1: every channel still started gets ch_timeout <= 1, ch_result <= 0, ch_start <= 0.
  - When no channel remains started after the update, go to FINISH.
- RUN_ONE:
  - Same per-channel rules, applied to the active index only.
  - When the active channel resolves: counter <= 0. If index == NUM_CH-1, go to FINISH; otherwise index+1 and ch_start <= 1 << (index+1) on the same edge, so there is no gap cycle.
- FINISH (entered one edge after the last channel resolves): busy <= 0; all_done <= 1; all_pass <= (&ch_result) & ~(|ch_timeout). Held until reset or the next start edge.
- Done edge and timeout in the same cycle: the done edge wins; the result is latched from ch_pass and no timeout is flagged.
- Done edges on channels not currently started are ignored, including spurious or late dones after a timeout.
- Start edge while busy=1: ignored. seq_mode changes mid-run: ignored.
- A channel whose ch_done is already high at launch needs a fresh 0->1 edge to resolve.
- Counter saturation cannot occur: it is cleared before exceeding TIMEOUT_CYC-1.
- Reset mid-run: immediate return to IDLE; ch_start drops asynchronously.

Optional Feature:
Macro HARNESS_FAIL_INDEX_EN.
- Defined:
  - adds outputs first_fail_valid (1 bit) and first_fail_idx ($clog2(NUM_CH) bits, min 1).
  - Both record the first channel to resolve as failed or timed out.
  - Lowest index wins among simultaneous failures.
  - Both are cleared on reset and on each start edge.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- NUM_CH=4, seq_mode=0; all channels raise done with pass=1 at cycles 5, 9, 12, 20 -> ch_result=4'b1111, all_done=1 one edge after cycle 20, all_pass=1, busy=0.
- Concurrent run; channel 2 done with pass=0 -> ch_result=4'b1011, all_pass=0; with the macro, first_fail_idx=2, first_fail_valid=1.
- TIMEOUT_CYC=50; channel 3 never signals done -> at counter 49, ch_timeout=4'b1000 and ch_start[3]=0, then all_done=1, all_pass=0.
- seq_mode=1; each channel done 3 cycles after its start -> ch_start walks 0001, 0010, 0100, 1000 with no idle gap; late done on channel 0 after it resolved -> ignored.
- Done edge on channel 1 on exactly the timeout cycle -> ch_timeout[1]=0, ch_result[1]=ch_pass[1].
- Second start edge mid-run -> ignored. Reset pulse mid-run -> all outputs 0 immediately. A subsequent start edge -> clean run with fresh results.
